// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU opcode codes and the highest legal code
//   - flag bit positions inside the {Z,N,C,V} nibble
//   - arbiter FSM state encoding
//   - helper to classify an opcode as legal
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [3:0] ALU_OP_MAX = ALU_SLTU;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
//   req_valid/req_ready : per-requester operation handshake (ready one-hot or zero)
//   req_a/req_b         : packed operands, requester i in [i*DATA_W +: DATA_W]
//   req_op              : packed opcodes, requester i in [i*4 +: 4]
//   rsp_valid/rsp_ready : per-requester response handshake (valid one-hot)
//   rsp_result/flags/err: shared response payload
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*4-1:0]      req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic [3:0]                rsp_flags;
  logic                      rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker.
//   valid_i : request vector
//   ptr_i   : index where the search starts (wraps NUM_REQ-1 -> 0)
//   grant_o : one-hot grant of the first asserted valid, zero if none
//   idx_o   : index of the granted requester (0 when none)
module alu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W:0]   cand_w;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand_w  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr_i is always below NUM_REQ, so one conditional subtract is a full modulo
      cand_w = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (cand_w >= (IDX_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (IDX_W+1)'(NUM_REQ);
      end
      cand = cand_w[IDX_W-1:0];
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU among NUM_REQ requesters.
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : requester handshakes and shared response bus
//   alu_a/alu_b/alu_ctrl: registered ALU operands and opcode
//   alu_result, alu_z/n/c/v : registered ALU outputs (one-cycle latency)
// Optional build macro ALU_ARB_OPCHK_EN: opcodes above ALU_OP_MAX are answered
// directly with rsp_err=1, result 0 and Z set, without reissuing the ALU.
//
// state | meaning
// IDLE  | arbitrate; grant winner, capture operands
// EXEC  | ALU registers the captured operands
// RESP  | present result to owner until its rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        ctrl_q, ctrl_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [DATA_W-1:0]  b_arr  [NUM_REQ];
  logic [3:0]         op_arr [NUM_REQ];
  logic [3:0]         win_op;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = bus.req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = bus.req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = bus.req_op[g*4 +: 4];
  end

  alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  assign win_op = op_arr[win_idx];

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = ctrl_q;

`ifdef ALU_ARB_OPCHK_EN
  logic err_q, err_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.rsp_err = (state_q == RESP) && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    a_d            = a_q;
    b_d            = b_q;
    ctrl_d         = ctrl_q;
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_result = '0;
    bus.rsp_flags  = '0;
`ifdef ALU_ARB_OPCHK_EN
    err_d          = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          bus.req_ready = grant;
          owner_d       = win_idx;
`ifdef ALU_ARB_OPCHK_EN
          if (!op_is_legal(win_op)) begin
            // operands stay untouched so the ALU outputs are not disturbed
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            a_d     = a_arr[win_idx];
            b_d     = b_arr[win_idx];
            ctrl_d  = win_op;
            state_d = EXEC;
          end
`else
          a_d     = a_arr[win_idx];
          b_d     = b_arr[win_idx];
          ctrl_d  = win_op;
          state_d = EXEC;
`endif
        end
      end

      EXEC: begin
        state_d = RESP;
      end

      RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_result         = alu_result;
        bus.rsp_flags          = {alu_z, alu_n, alu_c, alu_v};
`ifdef ALU_ARB_OPCHK_EN
        if (err_q) begin
          bus.rsp_result        = '0;
          bus.rsp_flags         = '0;
          bus.rsp_flags[FLAG_Z] = 1'b1;
        end
`endif
        if (bus.rsp_ready[owner_q]) begin
          state_d = IDLE;
          ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
`ifdef ALU_ARB_OPCHK_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference (round-robin search
// over pending requests plus an arithmetic ALU function).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_z, alu_n, alu_c, alu_v;
  logic [35:0]   alu_out_q;

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .alu_v      (alu_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {Z,N,C,V, result}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      default:  r = '0;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  // external registered ALU
  always @(posedge clk) alu_out_q <= alu_ref(alu_a, alu_b, alu_ctrl);
  assign alu_result = alu_out_q[31:0];
  assign {alu_z, alu_n, alu_c, alu_v} = alu_out_q[35:32];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // requester-side reference state
  bit          pend [NR];
  logic [31:0] pa   [NR];
  logic [31:0] pb   [NR];
  logic [3:0]  pop  [NR];
  int          ptr_m;
  logic [31:0] last_a, last_b;
  logic [3:0]  last_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = pend[i];
      bus.req_a[i*DW +: DW]    = pa[i];
      bus.req_b[i*DW +: DW]    = pb[i];
      bus.req_op[i*4 +: 4]     = pop[i];
    end
  endtask

  function automatic int exp_winner();
    int w;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      if (w < 0 && pend[(ptr_m + k) % NR]) w = (ptr_m + k) % NR;
    end
    return w;
  endfunction

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pend[i] = 1'b1; pop[i] = op; pa[i] = a; pb[i] = b;
  endtask

  // Entered and left at 1 time unit after a rising edge, in IDLE.
  task automatic serve(input int delay, input bit keep, output int w);
    logic [35:0] ex;
    bit          ill;
    logic [31:0] er;
    logic [3:0]  ef;
    w = exp_winner();
    drive();
    #1;
    chk("idle_hold_a", 64'(alu_a), 64'(last_a));
    chk("idle_hold_ctrl", 64'(alu_ctrl), 64'(last_c));
    chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    if (w < 0) begin
      chk("idle_no_grant", 64'(bus.req_ready), 64'(0));
      cyc();
      return;
    end
    chk("grant", 64'(bus.req_ready), 64'(4'(1) << w));
    ill = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
    ill = pop[w] > ALU_OP_MAX;
`endif
    ex = alu_ref(pa[w], pb[w], pop[w]);
    er = ill ? 32'd0 : ex[31:0];
    ef = ill ? 4'b1000 : ex[35:32];
    cyc();
    if (!keep) pend[w] = 1'b0;
    drive();
    if (!ill) begin
      #1;
      chk("exec_ready", 64'(bus.req_ready), 64'(0));
      chk("exec_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("exec_alu_a", 64'(alu_a), 64'(pa[w]));
      chk("exec_alu_b", 64'(alu_b), 64'(pb[w]));
      chk("exec_alu_ctrl", 64'(alu_ctrl), 64'(pop[w]));
      last_a = pa[w]; last_b = pb[w]; last_c = pop[w];
      cyc();
    end
    for (int d = 0; d <= delay; d++) begin
      bus.rsp_ready = 4'($urandom) & ~(4'(1) << w);
      if (d == delay) bus.rsp_ready[w] = 1'b1;
      #1;
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(4'(1) << w));
      chk("rsp_result", 64'(bus.rsp_result), 64'(er));
      chk("rsp_flags", 64'(bus.rsp_flags), 64'(ef));
      chk("rsp_err", 64'(bus.rsp_err), 64'(ill));
      chk("rsp_no_grant", 64'(bus.req_ready), 64'(0));
      chk("rsp_alu_b_held", 64'(alu_b), 64'(last_b));
      cyc();
    end
    bus.rsp_ready = 4'($urandom);
    ptr_m = (w + 1) % NR;
  endtask

  initial begin
    int w;
    reset_n       = 1'b0;
    bus.rsp_ready = '0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    drive();
    ptr_m = 0; last_a = '0; last_b = '0; last_c = '0;

    cyc(); cyc();
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    reset_n = 1'b1;
    cyc();

    // fairness: all four continuously valid, SUB 5-5
    for (int i = 0; i < NR; i++) set_req(i, ALU_SUB, 32'd5, 32'd5);
    for (int n = 0; n < 5; n++) serve(0, 1'b1, w);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;

    // single op with signed overflow
    set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    serve(0, 1'b0, w);

    // backpressure on req2
    set_req(2, ALU_SLTU, 32'd1, 32'd2);
    serve(5, 1'b0, w);

    // wrap and skip from ptr 3, then confirm pointer moved past req1
    set_req(1, ALU_OR, 32'h0F0F_0000, 32'h0000_F0F0);
    serve(0, 1'b0, w);
    set_req(0, ALU_XOR, $urandom, $urandom);
    set_req(2, ALU_AND, $urandom, $urandom);
    serve(1, 1'b0, w);
    serve(0, 1'b0, w);

    // undefined opcode
    set_req(3, 4'b1111, $urandom, $urandom);
    serve(0, 1'b0, w);
    serve(0, 1'b0, w);

    // reset during EXEC
    set_req(1, ALU_XOR, $urandom, $urandom);
    w = exp_winner();
    drive();
    #1;
    chk("mid_grant", 64'(bus.req_ready), 64'(4'(1) << w));
    cyc();
    pend[w] = 1'b0;
    drive();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.req_ready), 64'(0));
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("mid_rst_err", 64'(bus.rsp_err), 64'(0));
    chk("mid_rst_result", 64'(bus.rsp_result), 64'(0));
    chk("mid_rst_alu_a", 64'(alu_a), 64'(0));
    chk("mid_rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
    cyc();
    #1;
    chk("mid_rst_no_rsp", 64'(bus.rsp_valid), 64'(0));
    reset_n = 1'b1;
    ptr_m = 0; last_a = '0; last_b = '0; last_c = '0;
    cyc();
    set_req(0, ALU_SLL, 32'd1, 32'd4);
    set_req(2, ALU_ADD, $urandom, $urandom);
    serve(0, 1'b0, w);
    serve(0, 1'b0, w);

    // random traffic
    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 9) == 0)
            set_req(i, 4'($urandom_range(9, 15)), $urandom, $urandom);
          else
            set_req(i, 4'($urandom_range(0, 8)), $urandom, $urandom);
        end
      end
      serve(int'($urandom_range(0, 3)), 1'b0, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one registered 32-bit ALU (add/sub/or/and/xor/shl/shr/slt/sltu with Z/N/C/V flags) among several requesters. It accepts operations over per-requester valid/ready handshakes and drives the ALU operand and control inputs. It tracks the ALU's one-cycle registered latency and returns the result and flags to the winning requester on a shared response bus with a one-hot valid.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 32: operand and result width; must match the ALU
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*DATA_W  operand A; requester i in slice [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, packed as req_a
- req_op  in  NUM_REQ*4  ALU control code; requester i in slice [i*4 +: 4]
- rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_result  out  DATA_W  shared result bus
- rsp_flags  out  4  shared {Z,N,C,V}
- rsp_err  out  1  illegal opcode; only with ALU_ARB_OPCHK_EN, otherwise tied 0
- alu_a, alu_b  out  DATA_W  registered ALU operands
- alu_ctrl  out  4  registered ALU control
- alu_result  in  DATA_W  registered ALU result
- alu_z, alu_n, alu_c, alu_v  in  1  registered ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick winner w by round-robin from pointer ptr.
  - Assert req_ready[w] combinationally in this cycle only.
  - At the edge: register alu_a/alu_b/alu_ctrl from slice w, store w in owner, go to EXEC.
  - If no request, hold IDLE and keep the ALU operands unchanged.
- EXEC: the ALU samples the operands at this edge. Go to RESP unconditionally.
- RESP:
  - rsp_valid[owner]=1.
  - rsp_result and rsp_flags pass through from the ALU outputs, which stay stable while the operands are held.
  - On rsp_ready[owner]: go to IDLE and set ptr = (owner+1) mod NUM_REQ.
  - Otherwise hold with all outputs stable.
- Round-robin: search starts at ptr, wraps from NUM_REQ-1 to 0, and takes the first asserted valid. Ties cannot occur.
- Requesters must hold valid and payload stable until ready. The arbiter samples requests only in IDLE.
- rsp_ready of non-owners is ignored. req_valid is ignored outside IDLE; req_ready is 0 in EXEC and RESP.
- Flags are not interpreted; the ALU's own masking applies (C/V valid only for add/sub).

## Timing
- Reset (reset_n low, asynchronous):
  - state=IDLE, ptr=0, owner=0.
  - alu_a, alu_b, alu_ctrl = 0.
  - req_ready=0, rsp_valid=0, rsp_err=0.
- Reset mid-operation aborts the operation; no response is produced.
- Latency: accept in cycle 0, rsp_valid in cycle 2. Minimum 3 cycles per operation with immediate rsp_ready.
- A new grant can occur in the IDLE cycle right after the response handshake. There are no back-to-back grants without passing through IDLE.
- A request asserted in the same cycle as a response handshake is seen in the following IDLE cycle.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - In IDLE, a winning req_op > 4'b1000 is accepted normally.
  - The FSM goes directly to RESP with rsp_err=1, rsp_result=0 and rsp_flags=4'b1000. The ALU is not reissued.
  - Latency is 1 cycle.
- ALU_ARB_OPCHK_EN undefined:
  - All opcodes are forwarded; the ALU returns result 0 with Z=1 for undefined codes.
  - rsp_err is constant 0.

## Structure
- Shared package alu_pkg:
  - opcode localparams ALU_ADD=4'b0000, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU=4'b1000
  - ALU_OP_MAX
  - flag bit indices FLAG_Z=3..FLAG_V=0
  - arbiter state encoding IDLE/EXEC/RESP
- One sub-module: alu_rr_pick, purely combinational. Inputs are the valid vector and ptr; outputs are a one-hot grant and its index.
- FSM, owner/ptr registers and operand muxing live in alu_arbiter.

## Test plan
- Single op: req0 ADD A=0x7FFFFFFF, B=1, rsp_ready high → req_ready[0] in cycle 0, rsp_valid=4'b0001 in cycle 2, result=0x80000000, flags={0,1,0,1}.
- Fairness: all four valid continuously, ops SUB 5-5, rsp_ready high → grant order 0,1,2,3,0. Each response result=0 with Z=1, C=1, and the 3-cycle cadence holds.
- Backpressure: req2 SLTU A=1, B=2, rsp_ready low for 5 cycles → rsp_valid[2] held. Result=1 stays stable, no new grant, release completes in the next cycle.
- Wrap and skip: ptr=3, only req1 valid → req1 granted, ptr becomes 2 after the response.
- Reset mid-op: reset_n low during EXEC → next cycle all outputs are 0 and ptr=0. After release, req0 SHL A=1, B=4 returns 0x10.
- Illegal op: req_op=4'b1111 → with ALU_ARB_OPCHK_EN, rsp_err=1 and result 0 in cycle 1. Without it, result 0, Z=1, rsp_err=0 in cycle 2.
